// File: rtl/bn_hswish_stage.sv
// Per-channel scale/bias followed by identity, ReLU or hard-swish on a channel-serial Q-format stream.
// Three register stages (multiply, round+bias+saturate, activation); frames are sequenced by an IDLE/RUN/DONE FSM.
module bn_hswish_stage #(
  parameter  int N        = 16,
  parameter  int Q        = 8,
  parameter  int WIDTH    = 112,
  parameter  int HEIGHT   = 112,
  parameter  int CHANNELS = 16,
  parameter  int ACT      = 2,
  localparam int CHW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                cfg_we,
  input  logic [CHW-1:0]      cfg_addr,
  input  logic signed [N-1:0] cfg_scale,
  input  logic signed [N-1:0] cfg_bias,
  input  logic signed [N-1:0] data_in,
  input  logic [CHW-1:0]      channel_in,
  input  logic                valid_in,
  output logic signed [N-1:0] data_out,
  output logic [CHW-1:0]      channel_out,
  output logic                valid_out,
  output logic                done
);
  localparam int TOTAL = WIDTH * HEIGHT * CHANNELS;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam logic [CW-1:0] TOT  = CW'(TOTAL);
  localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);
  localparam logic signed [N-1:0]   ONE  = N'(1 << Q);
  localparam logic signed [47:0]    MAXV = (48'sd1 <<< (N - 1)) - 48'sd1;
  localparam logic signed [47:0]    MINV = -(48'sd1 <<< (N - 1));
  localparam logic signed [2*N:0]   RND  = {{(2*N+1-Q){1'b0}}, 1'b1, {(Q-1){1'b0}}};
  localparam logic signed [47:0]    THREE = 48'sd3 <<< Q;
  localparam logic signed [47:0]    SIX   = 48'sd6 <<< Q;
  localparam logic signed [47:0]    KSIX  = 48'sd10923;  // round(65536/6)
  localparam logic signed [47:0]    HALF  = 48'sd1 <<< (Q + 15);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         in_cnt_q, out_cnt_q;
  logic signed [N-1:0]   scale_q [CHANNELS];
  logic signed [N-1:0]   bias_q  [CHANNELS];
  logic [3:1]            vld_q;
  logic [CHW-1:0]        ch1_q, ch2_q, ch3_q;
  logic signed [2*N-1:0] m_q;
  logic signed [N-1:0]   y_q, out_q;
  logic                  accept;

  function automatic logic signed [N-1:0] sat(input logic signed [47:0] v);
    if (v > MAXV) return MAXV[N-1:0];
    if (v < MINV) return MINV[N-1:0];
    return v[N-1:0];
  endfunction

  // FSM: state register / next state / outputs
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN:     if (vld_q[3] && out_cnt_q == LAST) state_d = DONE;
      DONE:    if (!en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    done   = (state_q == DONE);
    accept = (state_q == RUN) && valid_in && (in_cnt_q < TOT) && (int'(channel_in) < CHANNELS);
  end

  // Counters sit at zero in IDLE so every frame starts from a clean count.
  always_ff @(posedge clk) begin
    if (rst || state_q == IDLE) begin
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      if (accept)   in_cnt_q  <= in_cnt_q + 1'b1;
      if (vld_q[3]) out_cnt_q <= out_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        scale_q[c] <= ONE;
        bias_q[c]  <= '0;
      end
    end else if (state_q == IDLE && cfg_we && int'(cfg_addr) < CHANNELS) begin
      scale_q[cfg_addr] <= cfg_scale;
      bias_q[cfg_addr]  <= cfg_bias;
    end
  end

  logic signed [2*N-1:0] x_ext, s_ext;
  logic signed [2*N:0]   m_ext, m_sh, b_ext, y_w;
  logic signed [47:0]    y48, t48, p48, h48;
  logic signed [N-1:0]   act_c;

  always_comb begin
    x_ext = {{N{data_in[N-1]}}, data_in};
    s_ext = {{N{scale_q[channel_in][N-1]}}, scale_q[channel_in]};
    m_ext = {m_q[2*N-1], m_q} + RND;
    m_sh  = m_ext >>> Q;
    b_ext = {{(N+1){bias_q[ch1_q][N-1]}}, bias_q[ch1_q]};
    y_w   = m_sh + b_ext;
    // hard-swish: y * clamp(y+3, 0, 6) / 6
    y48   = {{(48-N){y_q[N-1]}}, y_q};
    t48   = y48 + THREE;
    if (t48[47])        t48 = '0;
    else if (t48 > SIX) t48 = SIX;
    p48   = y48 * t48;
    h48   = (p48 * KSIX + HALF) >>> (Q + 16);
    if (ACT == 0)      act_c = y_q;
    else if (ACT == 1) act_c = y_q[N-1] ? '0 : y_q;
    else               act_c = sat(h48);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      ch1_q <= '0; ch2_q <= '0; ch3_q <= '0;
      m_q   <= '0; y_q   <= '0; out_q <= '0;
    end else begin
      vld_q <= {vld_q[2:1], accept};
      if (accept)   begin m_q <= x_ext * s_ext; ch1_q <= channel_in; end
      if (vld_q[1]) begin y_q <= sat({{(47-2*N){y_w[2*N]}}, y_w}); ch2_q <= ch1_q; end
      if (vld_q[2]) begin out_q <= act_c; ch3_q <= ch2_q; end
    end
  end

  assign data_out    = out_q;
  assign channel_out = ch3_q;
  assign valid_out   = vld_q[3];
endmodule

// File: tb/tb_bn_hswish_stage.sv
// Bench for bn_hswish_stage: three instances (ACT 0/1/2) share one stimulus stream; a scoreboard of
// expected results per activation is filled on drive and drained when valid_out pulses.
module tb_bn_hswish_stage;
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, cfg_we, valid_in;
  logic [1:0]  cfg_addr, channel_in;
  logic [15:0] cfg_scale, cfg_bias, data_in;
  logic [15:0] dout [3];
  logic [1:0]  chout [3];
  logic        vout [3];
  logic        done [3];

  for (genvar a = 0; a < 3; a++) begin : g_dut
    bn_hswish_stage #(.N(16), .Q(8), .WIDTH(2), .HEIGHT(2), .CHANNELS(4), .ACT(a)) u_dut (
      .clk(clk), .rst(rst), .en(en), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_scale(cfg_scale), .cfg_bias(cfg_bias), .data_in(data_in),
      .channel_in(channel_in), .valid_in(valid_in), .data_out(dout[a]),
      .channel_out(chout[a]), .valid_out(vout[a]), .done(done[a])
    );
  end

  typedef struct {
    logic [2:0][15:0] e;
    logic [1:0]       ch;
    int               stamp;
  } exp_t;

  exp_t        sb [$];
  logic [15:0] sh_s [4];
  logic [15:0] sh_b [4];
  int cyc = 0, total = 0, passed = 0, fails = 0, vcnt = 0, last_v = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint sat16(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Reference arithmetic in 64-bit integers, straight from the stage definitions.
  function automatic logic [15:0] model(input logic [15:0] x, input logic [15:0] s,
                                        input logic [15:0] b, input int act);
    longint m, y, t, h;
    m = longint'($signed(x)) * longint'($signed(s));
    y = sat16(((m + 128) >>> 8) + longint'($signed(b)));
    if (act == 0)      h = y;
    else if (act == 1) h = (y < 0) ? 0 : y;
    else begin
      t = y + 768;
      if (t < 0)    t = 0;
      if (t > 1536) t = 1536;
      h = sat16(((y * t) * 10923 + (longint'(1) << 23)) >>> 24);
    end
    return h[15:0];
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (vout[0] === 1'b1) begin
      vcnt++;
      last_v = cyc;
      chk("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("latency", cyc - e.stamp, 3);
        for (int a = 0; a < 3; a++) begin
          chk($sformatf("vld_act%0d", a), 32'(vout[a]), 1);
          chk($sformatf("data_act%0d", a), 32'(dout[a]), 32'(e.e[a]));
          chk($sformatf("ch_act%0d", a), 32'(chout[a]), 32'(e.ch));
        end
      end
    end
  end

  task automatic send(input logic [15:0] x, input logic [1:0] ch, input bit acc, input bit we);
    exp_t e;
    @(negedge clk);
    data_in = x; channel_in = ch; valid_in = 1'b1;
    cfg_we = we; cfg_addr = 2'd0; cfg_scale = 16'h0400; cfg_bias = 16'h0100;
    if (acc) begin
      e.ch = ch;
      e.stamp = cyc;
      for (int a = 0; a < 3; a++) e.e[a] = model(x, sh_s[ch], sh_b[ch], a);
      sb.push_back(e);
    end
  endtask

  task automatic cfg(input logic [1:0] addr, input logic [15:0] s, input logic [15:0] b, input bit start);
    @(negedge clk);
    valid_in = 1'b0; cfg_we = 1'b1; cfg_addr = addr; cfg_scale = s; cfg_bias = b; en = start;
    sh_s[addr] = s; sh_b[addr] = b;
  endtask

  task automatic start_frame();
    @(negedge clk);
    valid_in = 1'b0; cfg_we = 1'b0; en = 1'b1; vcnt = 0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done[0] !== 1'b1 && n < 40) begin
      @(negedge clk);
      valid_in = 1'b0; cfg_we = 1'b0;
      n++;
    end
    chk("done_seen", 32'(done[0]), 1);
    chk("done_one_after_last", cyc - last_v, 1);
    chk("done_act1", 32'(done[1]), 1);
    chk("done_act2", 32'(done[2]), 1);
    chk("frame_pulses", vcnt, 16);
    chk("sb_drained", sb.size(), 0);
  endtask

  task automatic end_frame();
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    for (int a = 0; a < 3; a++) chk($sformatf("done_low_act%0d", a), 32'(done[a]), 0);
  endtask

  logic [15:0] xs1 [16] = '{16'h0180, 16'hFF00, 16'h7FFF, 16'h8000, 16'h0000, 16'h0100, 16'hFE80, 16'h0300,
                            16'h0180, 16'h0040, 16'hFD00, 16'h0600, 16'h0180, 16'hFFFF, 16'h0080, 16'hF000};

  initial begin
    rst = 1'b1; en = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_scale = '0; cfg_bias = '0;
    data_in = '0; channel_in = '0; valid_in = 1'b0;
    for (int c = 0; c < 4; c++) begin sh_s[c] = 16'h0100; sh_b[c] = 16'h0000; end
    repeat (3) @(negedge clk);
    for (int a = 0; a < 3; a++) begin
      chk($sformatf("rst_data_act%0d", a), 32'(dout[a]), 0);
      chk($sformatf("rst_ch_act%0d", a), 32'(chout[a]), 0);
      chk($sformatf("rst_vld_act%0d", a), 32'(vout[a]), 0);
      chk($sformatf("rst_done_act%0d", a), 32'(done[a]), 0);
    end
    rst = 1'b0;

    // Frame 1: reset defaults; a cfg write mid-frame must not take effect; 17th sample dropped.
    start_frame();
    for (int i = 0; i < 16; i++) send(xs1[i], 2'(i % 4), 1'b1, i == 8);
    send(16'h0100, 2'd1, 1'b0, 1'b0);
    wait_done();
    end_frame();

    // Frame 2: ch2 scale 2.0 bias 1.0; ch3 scale 0x7FFF written in the same cycle as the start.
    vcnt = 0;
    cfg(2'd2, 16'h0200, 16'h0100, 1'b0);
    cfg(2'd3, 16'h7FFF, 16'h0000, 1'b1);
    send(16'h0180, 2'd2, 1'b1, 1'b0);
    send(16'h7FFF, 2'd3, 1'b1, 1'b0);
    send(16'h8000, 2'd3, 1'b1, 1'b0);
    send(16'hFF00, 2'd2, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) send(16'($urandom_range(0, 65535)), 2'($urandom_range(0, 3)), 1'b1, 1'b0);
    wait_done();
    end_frame();

    // Frame 3: reset after 7 samples aborts the frame and restores identity scale/bias.
    vcnt = 0;
    cfg(2'd1, 16'h0300, 16'hFF00, 1'b1);
    for (int i = 0; i < 7; i++) send(16'(16'h0100 + 16'(i * 64)), 2'(i % 4), 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1; valid_in = 1'b0; en = 1'b0;
    for (int c = 0; c < 4; c++) begin sh_s[c] = 16'h0100; sh_b[c] = 16'h0000; end
    @(negedge clk);
    for (int a = 0; a < 3; a++) begin
      chk($sformatf("midrst_vld_act%0d", a), 32'(vout[a]), 0);
      chk($sformatf("midrst_done_act%0d", a), 32'(done[a]), 0);
      chk($sformatf("midrst_data_act%0d", a), 32'(dout[a]), 0);
    end
    sb.delete();
    rst = 1'b0;

    // Frame 4: fresh frame with identity parameters on every channel.
    start_frame();
    send(16'h0180, 2'd2, 1'b1, 1'b0);
    send(16'h0180, 2'd1, 1'b1, 1'b0);
    send(16'h7FFF, 2'd3, 1'b1, 1'b0);
    for (int i = 0; i < 13; i++) send(16'($urandom_range(0, 65535)), 2'(i % 4), 1'b1, 1'b0);
    wait_done();
    end_frame();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
    $fatal(1);
  end
endmodule
